// File: rtl/ldtu_bsl_estimator_if.sv
// Control and data bundle between the pedestal estimator and its
// controller: run control and raw samples in, baseline and status out.
interface ldtu_bsl_estimator_if #(
  parameter int Nbits_12 = 12,
  parameter int Nbits_8  = 8
);
  logic                start;
  logic                abort;
  logic [Nbits_12-1:0] DATA12;
  logic [Nbits_8-1:0]  BSL_VAL;
  logic                bsl_done;
  logic                bsl_err;
  logic                bsl_sat;
  logic                busy;

  modport master (
    output start, abort, DATA12,
    input  BSL_VAL, bsl_done, bsl_err, bsl_sat, busy
  );

  modport slave (
    input  start, abort, DATA12,
    output BSL_VAL, bsl_done, bsl_err, bsl_sat, busy
  );
endinterface

// File: rtl/ldtu_bsl_estimator.sv
// Automatic pedestal estimator for one LiTe-DTU channel: skips settling
// samples, averages 2^LOG2_NSAMP raw samples, publishes a rounded 8-bit baseline.
module ldtu_bsl_estimator #(
  parameter int Nbits_12   = 12,
  parameter int Nbits_8    = 8,
  parameter int LOG2_NSAMP = 4,
  parameter int NSKIP      = 2,
  parameter int MAX_SPREAD = 16
) (
  input  logic                  DCLK,
  input  logic                  rst,
  ldtu_bsl_estimator_if.slave   bus
);

  localparam int ACC_W = Nbits_12 + LOG2_NSAMP;
  localparam logic [ACC_W-1:0]    ROUND_HALF = ACC_W'(1) << (LOG2_NSAMP - 1);
  localparam logic [ACC_W-1:0]    BSL_MAX    = ACC_W'((1 << Nbits_8) - 1);
  localparam logic [3:0]          SKIP_LAST  = 4'((NSKIP > 0) ? NSKIP - 1 : 0);
  localparam logic [Nbits_12-1:0] SPREAD_LIM = Nbits_12'(MAX_SPREAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam state_t FIRST_STATE = (NSKIP == 0) ? S_ACCUM : S_SKIP;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_skip_cnt;
  logic [LOG2_NSAMP-1:0] r_samp_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [Nbits_12-1:0]   r_min;
  logic [Nbits_12-1:0]   r_max;
  logic [Nbits_8-1:0]    r_bsl_val;
  logic                  r_bsl_done;
  logic                  r_bsl_err;
  logic                  r_bsl_sat;

  logic                  w_start_run;
  logic                  w_publish;
  logic                  w_last_samp;
  logic [ACC_W-1:0]      w_mean;
  logic [Nbits_12-1:0]   w_spread;

  assign w_start_run = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_publish   = (r_state == S_DONE) && !bus.abort;
  assign w_last_samp = &r_samp_cnt;
  // Accumulator headroom guarantees acc + N/2 cannot wrap before the shift.
  assign w_mean      = (r_acc + ROUND_HALF) >> LOG2_NSAMP;
  assign w_spread    = r_max - r_min;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_run) w_next_state = FIRST_STATE;
      S_SKIP: begin
        if (bus.abort)                     w_next_state = S_IDLE;
        else if (r_skip_cnt == SKIP_LAST)  w_next_state = S_ACCUM;
      end
      S_ACCUM: begin
        if (bus.abort)        w_next_state = S_IDLE;
        else if (w_last_samp) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) begin
      r_skip_cnt <= '0;
      r_samp_cnt <= '0;
      r_acc      <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_bsl_val  <= '0;
      r_bsl_done <= 1'b0;
      r_bsl_err  <= 1'b0;
      r_bsl_sat  <= 1'b0;
    end else begin
      r_bsl_done <= w_publish;
      case (r_state)
        S_IDLE: begin
          if (w_start_run) begin
            r_skip_cnt <= '0;
            r_samp_cnt <= '0;
            r_acc      <= '0;
            r_min      <= '1;
            r_max      <= '0;
          end
        end
        S_SKIP: begin
          if (!bus.abort) r_skip_cnt <= r_skip_cnt + 4'd1;
        end
        S_ACCUM: begin
          if (!bus.abort) begin
            r_acc      <= r_acc + ACC_W'(bus.DATA12);
            r_samp_cnt <= r_samp_cnt + 1'b1;
            if (bus.DATA12 < r_min) r_min <= bus.DATA12;
            if (bus.DATA12 > r_max) r_max <= bus.DATA12;
          end
        end
        S_DONE: begin
          if (w_publish) begin
            // A noisy run keeps the previously accepted baseline.
            if (w_spread > SPREAD_LIM) begin
              r_bsl_err <= 1'b1;
              r_bsl_sat <= 1'b0;
            end else if (w_mean > BSL_MAX) begin
              r_bsl_val <= BSL_MAX[Nbits_8-1:0];
              r_bsl_sat <= 1'b1;
              r_bsl_err <= 1'b0;
            end else begin
              r_bsl_val <= w_mean[Nbits_8-1:0];
              r_bsl_sat <= 1'b0;
              r_bsl_err <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BSL_VAL  = r_bsl_val;
  assign bus.bsl_done = r_bsl_done;
  assign bus.bsl_err  = r_bsl_err;
  assign bus.bsl_sat  = r_bsl_sat;
  assign bus.busy     = (r_state != S_IDLE);

endmodule
